crom_loader: RTL and testbench

CROM_LOADER -- requirements
Module: crom_loader

---
 rtl/crom_loader.sv | 166 ++++++++++++++++
 tb/tb_crom_loader.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crom_loader.sv
// Streams a ROM image into the cartridge over a Wishbone master port, writes the
// bank control register, and can read the image back to compare 8-bit checksums.
module crom_loader #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [14:0] length,
    input  logic        verify,
    input  logic        cfg_banked,
    input  logic        cfg_bank,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [17:0] wb_adr_o,
    output logic [7:0]  wb_dat_o,
    input  logic [7:0]  wb_dat_i,
    output logic        wb_we_o,
    output logic [0:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i
);

    localparam int unsigned TW      = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
    localparam logic [14:0] MAX_LEN = 15'd16384;

    typedef enum logic [2:0] {IDLE, FETCH, WRITE, CTRL, VREAD, FINISH} state_t;

    state_t        state, next_state;
    logic [14:0]   len_q, addr_q;
    logic          verify_q, banked_q, bank_q;
    logic [7:0]    byte_q, wr_sum, rd_sum, rd_sum_next;
    logic          gap_q, done_q, error_q;
    logic [TW-1:0] ack_timer;
    logic          in_bus, bus_ack, timeout, last_beat, start_ok;

    assign in_bus      = state inside {WRITE, CTRL, VREAD};
    // The slave acks at most every other cycle, so every ack is followed by one cycle with stb low.
    assign wb_stb_o    = in_bus && !gap_q;
    assign wb_cyc_o    = wb_stb_o;
    assign wb_we_o     = wb_stb_o && (state != VREAD);
    assign wb_sel_o[0] = wb_stb_o;
    assign bus_ack     = wb_stb_o && wb_ack_i;
    assign timeout     = wb_stb_o && !wb_ack_i && (ack_timer == TW'(ACK_TIMEOUT - 1));
    assign last_beat   = (addr_q + 15'd1) == len_q;
    assign start_ok    = (length != 15'd0) && (length <= MAX_LEN);
    assign rd_sum_next = rd_sum + wb_dat_i;

    assign s_ready = (state == FETCH);
    assign busy    = state inside {FETCH, WRITE, CTRL, VREAD};
    assign done    = (state == FINISH) || done_q;
    assign error   = error_q;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        next_state = state;
        case (state)
            IDLE:   if (start && start_ok) next_state = FETCH;
            FETCH:  if (s_valid) next_state = WRITE;
            WRITE: begin
                if (timeout)      next_state = IDLE;
                else if (bus_ack) next_state = last_beat ? CTRL : FETCH;
            end
            CTRL: begin
                if (timeout)      next_state = IDLE;
                else if (bus_ack) next_state = verify_q ? VREAD : FINISH;
            end
            VREAD: begin
                if (timeout)                   next_state = IDLE;
                else if (bus_ack && last_beat) next_state = FINISH;
            end
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Bus bit 17 is the control-register select; the data address sits in the low 14 bits.
    always_comb begin
        wb_adr_o = '0;
        wb_dat_o = '0;
        case (state)
            WRITE: begin
                wb_adr_o = {4'b0000, addr_q[13:0]};
                wb_dat_o = byte_q;
            end
            VREAD: wb_adr_o = {4'b0000, addr_q[13:0]};
            CTRL: begin
                wb_adr_o = 18'h20000;
                wb_dat_o = {3'b000, bank_q, 3'b000, banked_q};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            len_q     <= '0;
            addr_q    <= '0;
            verify_q  <= 1'b0;
            banked_q  <= 1'b0;
            bank_q    <= 1'b0;
            byte_q    <= '0;
            wr_sum    <= '0;
            rd_sum    <= '0;
            gap_q     <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            ack_timer <= '0;
        end else begin
            gap_q     <= bus_ack;
            done_q    <= 1'b0;
            ack_timer <= (wb_stb_o && !wb_ack_i) ? ack_timer + 1'b1 : '0;

            case (state)
                IDLE: begin
                    if (start && start_ok) begin
                        len_q    <= length;
                        verify_q <= verify;
                        banked_q <= cfg_banked;
                        bank_q   <= cfg_bank;
                        addr_q   <= '0;
                        wr_sum   <= '0;
                        rd_sum   <= '0;
                        error_q  <= 1'b0;
                    end else if (start) begin
                        done_q  <= 1'b1;
                        error_q <= 1'b1;
                    end
                end
                FETCH: begin
                    if (s_valid) begin
                        byte_q <= s_data;
                        wr_sum <= wr_sum + s_data;
                    end
                end
                WRITE: if (bus_ack) addr_q <= addr_q + 15'd1;
                CTRL:  if (bus_ack) addr_q <= '0;
                VREAD: begin
                    if (bus_ack) begin
                        addr_q <= addr_q + 15'd1;
                        rd_sum <= rd_sum_next;
                        // Flag the mismatch on the last read so error is valid alongside done.
                        if (last_beat) error_q <= (rd_sum_next != wr_sum);
                    end
                end
                default: ;
            endcase

            if (timeout) begin
                done_q  <= 1'b1;
                error_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_crom_loader.sv
// Self-checking bench for crom_loader: a memory slave, a stream driver and a
// transaction-level model of the expected bus traffic and error flag.
module tb_crom_loader;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b0;
    logic        start      = 1'b0;
    logic [14:0] length     = '0;
    logic        verify     = 1'b0;
    logic        cfg_banked = 1'b0;
    logic        cfg_bank   = 1'b0;
    logic [7:0]  s_data     = '0;
    logic        s_valid    = 1'b0;
    logic        s_ready, busy, done, error;
    logic [17:0] wb_adr_o;
    logic [7:0]  wb_dat_o;
    logic [7:0]  wb_dat_i   = '0;
    logic        wb_we_o;
    logic [0:0]  wb_sel_o;
    logic        wb_stb_o, wb_cyc_o;
    logic        wb_ack_i   = 1'b0;

    always #5 clk = ~clk;

    crom_loader #(.ACK_TIMEOUT(255)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .length     (length),
        .verify     (verify),
        .cfg_banked (cfg_banked),
        .cfg_bank   (cfg_bank),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_we_o    (wb_we_o),
        .wb_sel_o   (wb_sel_o),
        .wb_stb_o   (wb_stb_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_ack_i   (wb_ack_i)
    );

    typedef struct {
        bit we;
        int adr;
        int dat;
    } txn_t;

    int   checks   = 0;
    int   failures = 0;

    // Slave / model state
    logic [7:0] mem [16384];
    txn_t       log_q[$];
    logic [7:0] data_q[$];
    bit         no_ack      = 1'b0;
    int         max_delay   = 2;
    int         dly         = 0;
    int         corrupt_adr = -1;
    logic [7:0] corrupt_val = '0;

    // Monitor state
    int done_cnt    = 0;
    bit err_at_done = 1'b0;
    int stb_run     = 0;
    int last_run    = 0;
    int xfer_cnt    = 0;
    int gap_viol    = 0;
    int ready_viol  = 0;
    int sel_viol    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wishbone slave: acks after a random delay, one cycle wide, and logs each accepted cycle.
    always @(negedge clk) begin
        if (!reset_n) begin
            wb_ack_i = 1'b0;
        end else if (wb_ack_i) begin
            if (wb_stb_o) gap_viol++;
            wb_ack_i = 1'b0;
        end else if (wb_stb_o && wb_cyc_o && !no_ack) begin
            if (dly > 0) begin
                dly--;
            end else begin
                wb_ack_i = 1'b1;
                if (wb_we_o) begin
                    if (wb_sel_o !== 1'b1) sel_viol++;
                    if (wb_adr_o < 18'h20000) mem[int'(wb_adr_o[13:0])] = wb_dat_o;
                    log_q.push_back('{1'b1, int'(wb_adr_o), int'(wb_dat_o)});
                end else begin
                    if (int'(wb_adr_o) == corrupt_adr) wb_dat_i = corrupt_val;
                    else                               wb_dat_i = mem[int'(wb_adr_o[13:0])];
                    log_q.push_back('{1'b0, int'(wb_adr_o), int'(wb_dat_i)});
                end
                dly = int'($urandom_range(max_delay, 0));
            end
        end
    end

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            err_at_done = error;
        end
        if (wb_stb_o) begin
            stb_run++;
        end else begin
            if (stb_run > 0) last_run = stb_run;
            stb_run = 0;
        end
        if (s_valid && s_ready) xfer_cnt++;
        if (s_ready && wb_stb_o) ready_viol++;
    end

    task automatic wait_done(input int d0, input int budget, output bit ok);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (done_cnt != d0);
    endtask

    task automatic pulse_start(input int len, input bit vfy, input bit bnk_en, input bit bnk);
        length     = 15'(len);
        verify     = vfy;
        cfg_banked = bnk_en;
        cfg_bank   = bnk;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    // Presents one byte and returns after the edge that consumed it.
    task automatic send_byte(input string tag, input logic [7:0] b);
        int n = 0;
        s_data  = b;
        s_valid = 1'b1;
        while (!s_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check({tag, "_stream_timeout"}, 32'(n), 32'd0);
        @(negedge clk);
    endtask

    function automatic int count_reads();
        int n = 0;
        foreach (log_q[i]) if (!log_q[i].we) n++;
        return n;
    endfunction

    function automatic int read_sum();
        int s = 0;
        foreach (log_q[i]) if (!log_q[i].we) s += log_q[i].dat;
        return s & 255;
    endfunction

    function automatic int ctrl_dat();
        int d = -1;
        foreach (log_q[i]) if (log_q[i].we && log_q[i].adr == 32'h20000) d = log_q[i].dat;
        return d;
    endfunction

    function automatic int max_write_adr();
        int m = -1;
        foreach (log_q[i]) if (log_q[i].we && log_q[i].adr < 32'h20000 && log_q[i].adr > m) m = log_q[i].adr;
        return m;
    endfunction

    // Full load of data_q against the model; poke fires a second start while busy.
    task automatic run_load(input string tag, input int len, input bit vfy, input bit bnk_en,
                            input bit bnk, input int stall, input bit poke);
        txn_t exp_q[$];
        int   d0, x0, wsum, rsum, bad, rb;
        bit   ok, exp_err;
        wsum = 0;
        rsum = 0;
        bad  = 0;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back('{1'b1, i, int'(data_q[i])});
            wsum += int'(data_q[i]);
        end
        exp_q.push_back('{1'b1, 32'h20000, (bnk ? 32'h10 : 0) | (bnk_en ? 32'h01 : 0)});
        if (vfy) begin
            for (int i = 0; i < len; i++) begin
                rb = (i == corrupt_adr) ? int'(corrupt_val) : int'(data_q[i]);
                exp_q.push_back('{1'b0, i, rb});
                rsum += rb;
            end
        end
        exp_err = vfy && ((wsum & 255) != (rsum & 255));

        log_q.delete();
        d0 = done_cnt;
        x0 = xfer_cnt;
        pulse_start(len, vfy, bnk_en, bnk);
        check({tag, "_busy"}, busy, 1'b1);
        for (int i = 0; i < len; i++) begin
            send_byte(tag, data_q[i]);
            if (poke && i == 0) begin
                s_valid = 1'b0;
                pulse_start(3, !vfy, !bnk_en, !bnk);
            end
            if (stall > 0) begin
                s_valid = 1'b0;
                repeat (stall) @(negedge clk);
            end
        end
        s_valid = 1'b0;

        wait_done(d0, 2000, ok);
        check({tag, "_done_seen"}, ok, 1'b1);
        check({tag, "_error"}, err_at_done, exp_err);
        repeat (3) @(negedge clk);
        check({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_consumed"}, 32'(xfer_cnt - x0), 32'(len));
        check({tag, "_busy_after"}, busy, 1'b0);
        check({tag, "_bus_count"}, 32'(log_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i >= log_q.size()) bad++;
            else if (log_q[i].we != exp_q[i].we || log_q[i].adr != exp_q[i].adr ||
                     log_q[i].dat != exp_q[i].dat) bad++;
        end
        check({tag, "_bus_content_bad"}, 32'(bad), 32'd0);
    endtask

    task automatic bad_start(input string tag, input int len);
        int d0;
        bit ok;
        log_q.delete();
        d0 = done_cnt;
        pulse_start(len, 1'b0, 1'b0, 1'b0);
        wait_done(d0, 10, ok);
        check({tag, "_done_seen"}, ok, 1'b1);
        check({tag, "_error"}, err_at_done, 1'b1);
        repeat (5) @(negedge clk);
        check({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_no_bus"}, 32'(log_q.size() + last_run * 0 + (busy ? 1 : 0)), 32'd0);
        check({tag, "_error_held"}, error, 1'b1);
    endtask

    initial begin
        int  d0, n, len, stall;
        bit  ok, vfy, b1, b2;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_cyc", wb_cyc_o, 1'b0);
        check("rst_stb", wb_stb_o, 1'b0);
        check("rst_we", wb_we_o, 1'b0);
        check("rst_adr", 32'(wb_adr_o), 32'd0);
        check("rst_dat", 32'(wb_dat_o), 32'd0);
        check("rst_sel", 32'(wb_sel_o), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic load, then verified load with a start pulse while busy, then a corrupted readback
        data_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_load("basic", 4, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        check("basic_ctrl_dat", 32'(ctrl_dat()), 32'h11);
        run_load("verify", 4, 1'b1, 1'b1, 1'b1, 0, 1'b1);
        check("verify_reads", 32'(count_reads()), 32'd4);
        check("verify_sum", 32'(read_sum()), 32'hAA);
        corrupt_adr = 2;
        corrupt_val = 8'h34;
        run_load("corrupt", 4, 1'b1, 1'b1, 1'b1, 0, 1'b0);
        check("corrupt_error_level", error, 1'b1);
        corrupt_adr = -1;

        // Source stalls of 10 cycles between bytes
        run_load("stall", 4, 1'b0, 1'b0, 1'b1, 10, 1'b0);

        // Randomized loads
        for (int t = 0; t < 6; t++) begin
            len = int'($urandom_range(24, 1));
            data_q.delete();
            for (int i = 0; i < len; i++) data_q.push_back(8'($urandom));
            vfy   = 1'($urandom_range(1, 0));
            b1    = 1'($urandom_range(1, 0));
            b2    = 1'($urandom_range(1, 0));
            stall = int'($urandom_range(3, 0));
            corrupt_adr = -1;
            if (vfy && $urandom_range(1, 0) == 1) begin
                corrupt_adr = int'($urandom_range(len - 1, 0));
                corrupt_val = data_q[corrupt_adr] ^ 8'($urandom_range(255, 1));
            end
            run_load("rand", len, vfy, b1, b2, stall, 1'b0);
        end
        corrupt_adr = -1;

        // Illegal lengths
        bad_start("len0", 0);
        bad_start("len16385", 16385);

        // Slave never acks
        no_ack = 1'b1;
        log_q.delete();
        d0 = done_cnt;
        pulse_start(1, 1'b0, 1'b0, 1'b0);
        send_byte("timeout", 8'h5A);
        s_valid = 1'b0;
        wait_done(d0, 600, ok);
        check("timeout_done_seen", ok, 1'b1);
        check("timeout_error", err_at_done, 1'b1);
        check("timeout_stb_cycles", 32'(last_run), 32'd255);
        repeat (5) @(negedge clk);
        check("timeout_done_once", 32'(done_cnt - d0), 32'd1);
        check("timeout_cyc_low", wb_cyc_o, 1'b0);

        // Reset in the middle of a bus cycle
        d0 = done_cnt;
        pulse_start(2, 1'b0, 1'b0, 1'b0);
        send_byte("rst_mid", 8'h77);
        s_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_mid_stb_before", wb_stb_o, 1'b1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_stb", wb_stb_o, 1'b0);
        check("rst_mid_cyc", wb_cyc_o, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
        no_ack = 1'b0;

        // Maximum length
        max_delay = 0;
        data_q.delete();
        for (int i = 0; i < 16384; i++) data_q.push_back(8'($urandom));
        run_load("maxlen", 16384, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        check("maxlen_last_adr", 32'(max_write_adr()), 32'h3FFF);

        check("gap_violations", 32'(gap_viol), 32'd0);
        check("ready_stb_overlap", 32'(ready_viol), 32'd0);
        check("sel_violations", 32'(sel_viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
